// File: rtl/ddr2_resp_sim.sv
// ddr2_resp_sim: single-clock stand-in for the DDR2 controller subsystem.
// Serves a write port and a read port from an internal word array, arbitrating
// round-robin and completing each access after a fixed latency through the
// waitrequest handshake (one access outstanding at a time).
// Optional: define DDR2_RESP_ADDR_CHECK_EN to enable the sticky out-of-range
// address flag (addr_err); otherwise addr_err is tied low.
module ddr2_resp_sim #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int WR_LATENCY = 2,
  parameter int RD_LATENCY = 4
) (
  input  logic              ctrl_clk,
  input  logic              reset,
  input  logic [31:0]       write_write_addr,
  input  logic [DATA_W-1:0] write_iData,
  input  logic              write_write,
  output logic              write_waitrequest,
  input  logic [31:0]       read_read_addr,
  input  logic              read_read,
  output logic [DATA_W-1:0] read_oData,
  output logic              read_waitrequest,
  output logic              addr_err
);

  localparam int AW     = $clog2(DEPTH);
  localparam int MAXLAT = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
  localparam int CW     = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    RD_WAIT,
    WR_DONE,
    RD_DONE
  } state_t;

  typedef enum logic {
    GRANT_WR,
    GRANT_RD
  } grant_t;

  state_t            state;
  grant_t            last_grant;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic              pick_wr;
  logic              wr_commit;

  assign wr_idx = write_write_addr[AW+1:2];
  assign rd_idx = read_read_addr[AW+1:2];

  // Arbitration: a lone request wins; on a tie the port not granted last wins.
  always_comb begin
    pick_wr = 1'b0;
    if (write_write && (!read_read || last_grant == GRANT_RD))
      pick_wr = 1'b1;
  end

  assign wr_commit = (state == WR_WAIT) && write_write && (cnt == '0);

  // Array write at the WR_WAIT -> WR_DONE edge; contents survive reset.
  always_ff @(posedge ctrl_clk) begin
    if (wr_commit)
      mem[wr_idx] <= write_iData;
  end

  // Access FSM with registered waitrequests and read data.
  always_ff @(posedge ctrl_clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      write_waitrequest <= 1'b1;
      read_waitrequest  <= 1'b1;
      read_oData        <= '0;
      last_grant        <= GRANT_RD;
      cnt               <= '0;
`ifdef DDR2_RESP_ADDR_CHECK_EN
      addr_err          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pick_wr) begin
            last_grant <= GRANT_WR;
            cnt        <= CW'(WR_LATENCY - 1);
            state      <= WR_WAIT;
`ifdef DDR2_RESP_ADDR_CHECK_EN
            if (|write_write_addr[31:AW+2])
              addr_err <= 1'b1;
`endif
          end else if (read_read) begin
            last_grant <= GRANT_RD;
            cnt        <= CW'(RD_LATENCY - 1);
            state      <= RD_WAIT;
`ifdef DDR2_RESP_ADDR_CHECK_EN
            if (|read_read_addr[31:AW+2])
              addr_err <= 1'b1;
`endif
          end
        end
        WR_WAIT: begin
          if (!write_write) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state             <= WR_DONE;
            write_waitrequest <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RD_WAIT: begin
          if (!read_read) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state            <= RD_DONE;
            read_oData       <= mem[rd_idx];
            read_waitrequest <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_DONE: begin
          write_waitrequest <= 1'b1;
          state             <= IDLE;
        end
        RD_DONE: begin
          read_waitrequest <= 1'b1;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR2_RESP_ADDR_CHECK_EN
  logic unused_addr_bits;
  assign unused_addr_bits = ^{write_write_addr[1:0], read_read_addr[1:0]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{write_write_addr[31:AW+2], write_write_addr[1:0],
                              read_read_addr[31:AW+2], read_read_addr[1:0]};
  assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_ddr2_resp_sim.sv
// Directed self-checking bench for ddr2_resp_sim (default parameters).
module tb_ddr2_resp_sim;

  localparam int DW  = 32;
  localparam int WRL = 2;
  localparam int RDL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   write_write_addr = '0;
  logic [DW-1:0] write_iData = '0;
  logic          write_write = 1'b0;
  logic          write_waitrequest;
  logic [31:0]   read_read_addr = '0;
  logic          read_read = 1'b0;
  logic [DW-1:0] read_oData;
  logic          read_waitrequest;
  logic          addr_err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] last_rd = '0;
  logic          exp_err_flag;

  ddr2_resp_sim #(
    .DATA_W(DW), .DEPTH(1024), .WR_LATENCY(WRL), .RD_LATENCY(RDL)
  ) dut (
    .ctrl_clk(clk), .reset(rst),
    .write_write_addr(write_write_addr), .write_iData(write_iData),
    .write_write(write_write), .write_waitrequest(write_waitrequest),
    .read_read_addr(read_read_addr), .read_read(read_read),
    .read_oData(read_oData), .read_waitrequest(read_waitrequest),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Write transaction; n counts negedges after request until waitrequest seen low.
  task automatic do_write(input logic [31:0] a, input logic [DW-1:0] d, input string nm);
    int n = 0;
    bit done = 0;
    @(negedge clk);
    write_write_addr = a; write_iData = d; write_write = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk); n++;
      if (!write_waitrequest) done = 1;
    end
    write_write = 1'b0;
    chk({nm, " wr latency"}, 64'(n), 64'(WRL + 1));
    @(negedge clk);
    chk({nm, " wr one-cycle"}, 64'(write_waitrequest), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [DW-1:0] exp, input string nm);
    int n = 0;
    bit done = 0;
    bit held = 1;
    @(negedge clk);
    read_read_addr = a; read_read = 1'b1;
    while (!done && n < 50) begin
      @(negedge clk); n++;
      if (!read_waitrequest) done = 1;
      else if (read_oData !== last_rd) held = 0;
    end
    read_read = 1'b0;
    chk({nm, " rd latency"}, 64'(n), 64'(RDL + 1));
    chk({nm, " rd held"}, 64'(held), 64'd1);
    chk({nm, " rd data"}, 64'(read_oData), 64'(exp));
    last_rd = exp;
    @(negedge clk);
    chk({nm, " rd one-cycle"}, 64'(read_waitrequest), 64'd1);
  endtask

  // Both requests asserted together; records the negedge index of each completion.
  task automatic do_pair(input logic [31:0] wa, input logic [DW-1:0] wd,
                         input logic [31:0] ra, input logic [DW-1:0] rexp,
                         input int exp_wn, input int exp_rn, input string nm);
    int n = 0;
    int wn = 0;
    int rn = 0;
    logic [DW-1:0] rdata = '0;
    @(negedge clk);
    write_write_addr = wa; write_iData = wd; write_write = 1'b1;
    read_read_addr = ra; read_read = 1'b1;
    while ((wn == 0 || rn == 0) && n < 60) begin
      @(negedge clk); n++;
      if (!write_waitrequest && wn == 0) begin wn = n; write_write = 1'b0; end
      if (!read_waitrequest && rn == 0) begin rn = n; read_read = 1'b0; rdata = read_oData; end
    end
    write_write = 1'b0; read_read = 1'b0;
    chk({nm, " write done at"}, 64'(wn), 64'(exp_wn));
    chk({nm, " read done at"}, 64'(rn), 64'(exp_rn));
    chk({nm, " read data"}, 64'(rdata), 64'(rexp));
    last_rd = rexp;
    @(negedge clk);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
`ifdef DDR2_RESP_ADDR_CHECK_EN
    exp_err_flag = 1'b1;
`else
    exp_err_flag = 1'b0;
`endif
    // For reads, data holds the expected value.
    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h0000_0013, 32'hA5A5_A5A5};  // bits [1:0] ignored: index 4
    vecs[4] = '{1'b0, 32'h0000_0010, 32'hA5A5_A5A5};
    vecs[5] = '{1'b0, 32'h0000_0014, 32'h1234_5678};
    vecs[6] = '{1'b1, 32'h0000_0FFC, 32'h0000_0001};
    vecs[7] = '{1'b0, 32'h0000_0FFC, 32'h0000_0001};

    repeat (3) @(negedge clk);
    chk("reset wr_wait", 64'(write_waitrequest), 64'd1);
    chk("reset rd_wait", 64'(read_waitrequest), 64'd1);
    chk("reset oData", 64'(read_oData), 64'd0);
    chk("reset addr_err", 64'(addr_err), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // First tie after reset: write first (3), read granted after a gap (2+4+3=9).
    do_pair(32'h40, 32'hAAAA_0001, 32'h40, 32'hAAAA_0001, WRL + 1, WRL + RDL + 3, "pair1");
    // Pair1 ended on a read grant; a lone write makes the next tie go to read.
    do_write(32'h44, 32'hBBBB_0002, "lone");
    do_pair(32'h40, 32'hCCCC_0003, 32'h40, 32'hAAAA_0001, RDL + WRL + 3, RDL + 1, "pair2");
    do_read(32'h40, 32'hCCCC_0003, "pair2 after");

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
      else            do_read(vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
    end
    chk("in-range addr_err", 64'(addr_err), 64'd0);

    for (int i = 0; i < 640; i++)
      do_write(32'(i * 4), 32'(i), $sformatf("line w%0d", i));
    for (int i = 0; i < 640; i++)
      do_read(32'(i * 4), 32'(i), $sformatf("line r%0d", i));

    // Read abandoned during RD_WAIT: no completion, data untouched.
    begin
      bit quiet = 1;
      @(negedge clk);
      read_read_addr = 32'h10; read_read = 1'b1;
      repeat (2) @(negedge clk);
      read_read = 1'b0;
      repeat (10) begin
        @(negedge clk);
        if (read_waitrequest !== 1'b1 || read_oData !== last_rd) quiet = 0;
      end
      chk("abort rd quiet", 64'(quiet), 64'd1);
      chk("abort rd oData", 64'(read_oData), 64'(last_rd));
    end
    do_write(32'h18, 32'h0BAD_CAFE, "post-abort");
    do_read(32'h18, 32'h0BAD_CAFE, "post-abort");

    // Reset in WR_WAIT: index 8 must keep its loop value.
    @(negedge clk);
    write_write_addr = 32'h20; write_iData = 32'h2222_2222; write_write = 1'b1;
    @(negedge clk);
    rst = 1'b1; write_write = 1'b0;
    #1;
    chk("mid-reset wr_wait", 64'(write_waitrequest), 64'd1);
    chk("mid-reset rd_wait", 64'(read_waitrequest), 64'd1);
    chk("mid-reset oData", 64'(read_oData), 64'd0);
    last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    do_read(32'h20, 32'h0000_0008, "after reset idx8");
    do_read(32'h0C, 32'h0000_0003, "after reset idx3");

    // Out-of-range write aliases onto index 0.
    do_write(32'h1000, 32'hCAFE_F00D, "oob");
    chk("oob addr_err", 64'(addr_err), 64'(exp_err_flag));
    do_read(32'h0, 32'hCAFE_F00D, "alias");
    chk("addr_err sticky", 64'(addr_err), 64'(exp_err_flag));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
